qea_host_loader: RTL and testbench
==================================

// Module: qea_host_loader
// PURPOSE
//  Host-side initiator for the QEA core's load/run/readout interface.
//  - Streams gate-context words and initial state vectors into QEA.
//  - Pulses start, then waits for complete.
//  - Streams the final state vectors back out over valid/ready.
//  - Replaces bench-driven port wiggling in synthesised top-levels.
// PARAMETERS
//  PE_NUM_WIDTH            2    log2 of PE count
//  PE_NUM                  4    processing elements; one state word holds PE_NUM amplitudes
//  DATA_WIDTH              32   real/imag component width
//  STATE_DATA_WIDTH        64   DATA_WIDTH*2, one complex amplitude
//  STATE_ADDR_WIDTH        16   QEA state RAM address width
//  GATE_CONTEXT_DATA_WIDTH 64   context word width
//  GATE_CONTEXT_ADDR_WIDTH 16   context RAM address width
//  MAX_QBIT_WIDTH          6    width of the qubit-count field
//  READ_LAT                1    QEA state RAM read latency, in cycles (>=1)
// PORTS
//  clk               in   1                       clock
//  rst               in   1                       synchronous active-high reset
//  i_go              in   1                       launch job; sampled in IDLE only
//  i_qbit_num        in   MAX_QBIT_WIDTH          qubit count, latched on i_go
//  i_ctx_num         in   GATE_CONTEXT_ADDR_WIDTH context word count, latched on i_go
//  i_ctx_valid       in   1                       context stream valid
//  i_ctx_word        in   GATE_CONTEXT_DATA_WIDTH context stream data
//  o_ctx_ready       out  1                       context stream ready
//  i_st_valid        in   1                       initial-state stream valid
//  i_st_word         in   PE_NUM*STATE_DATA_WIDTH initial-state data, PE0 in LSBs
//  o_st_ready        out  1                       initial-state stream ready
//  o_rd_valid        out  1                       result stream valid
//  o_rd_word         out  PE_NUM*STATE_DATA_WIDTH result data
//  o_rd_addr         out  STATE_ADDR_WIDTH        state address of o_rd_word
//  i_rd_ready        in   1                       result stream ready
//  o_qea_start       out  1                       to QEA i_start
//  o_qea_qbit_num    out  MAX_QBIT_WIDTH          to QEA i_qbit_num
//  o_qea_ctx_en/_wea out  1 each                  to QEA i_ctx_en / i_ctx_wea
//  o_qea_ctx_addr    out  GATE_CONTEXT_ADDR_WIDTH to QEA i_ctx_addr
//  o_qea_ctx_data    out  GATE_CONTEXT_DATA_WIDTH to QEA i_ctx_data
//  o_qea_state_ena   out  1                       to QEA i_state_ena
//  o_qea_state_wea   out  1                       to QEA i_state_wea
//  o_qea_state_addra out  STATE_ADDR_WIDTH        to QEA i_state_addra
//  o_qea_state_dina  out  PE_NUM*STATE_DATA_WIDTH to QEA i_state_dina
//  i_qea_complete    in   1                       from QEA o_complete
//  i_qea_state_dout  in   PE_NUM*STATE_DATA_WIDTH from QEA o_state_dout
//  o_busy            out  1                       job in progress
//  o_done            out  1                       one-cycle pulse at job end
//  o_err             out  1                       one-cycle pulse on rejected i_go
// BEHAVIOUR
//  - Reset: every output 0, FSM to IDLE, counters cleared, skid buffer emptied,
//    in-flight reads dropped. Reset mid-job aborts the job with no o_done.
//  - DEPTH = 2**(qbit - PE_NUM_WIDTH).
//  - Legal qbit range: PE_NUM_WIDTH < qbit <= STATE_ADDR_WIDTH + PE_NUM_WIDTH.
//    On i_go in IDLE with an illegal qbit: pulse o_err, stay IDLE.
//    i_go outside IDLE is ignored.
//  - FSM: IDLE -> LOAD_CTX -> LOAD_STATE -> START -> RUN -> READ -> DONE -> IDLE.
//  - LOAD_CTX:
//    - o_ctx_ready=1.
//    - Each handshake drives ctx_en=wea=1, addr=counter (from 0), data=word for exactly that cycle.
//    - After i_ctx_num words -> LOAD_STATE.
//    - i_ctx_num==0 skips LOAD_CTX.
//  - LOAD_STATE: same scheme on the state port; addresses 0..DEPTH-1, then -> START.
//  - START: o_qea_start=1 for one cycle.
//  - RUN:
//    - i_qea_complete is ignored in the first cycle after START.
//    - From the second cycle on, complete=1 -> READ.
//    - No timeout.
//  - READ:
//    - Issue ena=1, wea=0 at addr 0..DEPTH-1.
//    - Data returns READ_LAT cycles later into the skid buffer.
//    - Issue only while occupancy + in-flight < READ_LAT+1, so there is no loss under backpressure.
//    - Output is in address order; o_rd_addr is tagged through the pipe.
//    - o_rd_valid, once high, holds with stable data until i_rd_ready.
//    - Last word accepted -> DONE.
//  - DONE: o_done=1 for one cycle -> IDLE.
//  - o_busy=1 in every state except IDLE.
//  - o_qea_qbit_num holds the latched value.
//  - Address counters never wrap within a job (DEPTH <= 2**STATE_ADDR_WIDTH).
// CONFIGURATION
//  QEA_HOST_CYCLE_CNT_EN
//  - Defined: adds output o_exec_cycles [31:0].
//    - Cleared on START, increments each RUN cycle, saturates at all-ones.
//    - Frozen from READ onward; equals RUN duration in cycles.
//  - Undefined: port and counter are absent.
// STRUCTURE
//  - Package qea_host_pkg: FSM state enum; function depth_of(qbit);
//    function qbit_legal(qbit); default READ_LAT.
//  - Sub-module qea_host_rd_skid: (READ_LAT+1)-entry FIFO holding {addr, word}
//    on the readout path.
// TESTING
//  - Basic job: qbit=4, ctx_num=3, state word0 amp0=0x40000000_00000000, rest 0.
//    QEA model copies state through. Expect ctx writes at addrs 0..2, state
//    writes at 0..3, one start pulse, 4 readout words with word0 returned
//    intact, then o_done.
//  - i_go with qbit=2 or qbit=19 -> o_err pulse, o_busy stays 0, no QEA port
//    activity.
//  - ctx_num=0 -> FSM goes straight to LOAD_STATE, ctx_en never asserted.
//  - Readout with i_rd_ready toggling 1-0-0-1 and READ_LAT=2 -> every address
//    0..3 delivered exactly once, in order, with no data change while stalled.
//  - Assert rst during RUN -> all outputs 0 next cycle, no o_done. A fresh i_go
//    afterwards completes normally.
//  - QEA_HOST_CYCLE_CNT_EN defined, model raises complete 10 cycles after start
//    -> o_exec_cycles==10.

Source files
------------

// File: rtl/qea_host_pkg.sv
// qea_host_pkg: FSM states, job-sizing helpers and default read latency shared by qea_host_loader.
package qea_host_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_CTX, S_LOAD_STATE, S_START, S_RUN, S_READ, S_DONE
   } state_t;
   localparam int DEF_READ_LAT = 1;
   function automatic logic qbit_legal(input int qbit, input int pe_w, input int addr_w);
      return qbit > pe_w && qbit <= addr_w + pe_w;
   endfunction
   function automatic int depth_of(input int qbit, input int pe_w);
      return 1 << (qbit - pe_w);
   endfunction
endpackage

// File: rtl/qea_host_rd_skid.sv
// qea_host_rd_skid: small circular FIFO holding {addr, word} on the readout path.
module qea_host_rd_skid #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic                         o_valid,
   output logic [W-1:0]                 o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [NW-1:0] r_cnt;
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
         if (i_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
         r_cnt <= r_cnt + NW'(i_push) - NW'(i_pop);
      end
   end
   assign o_valid = r_cnt != '0;
   assign o_data  = r_mem[r_rd];
   assign o_count = r_cnt;
endmodule

// File: rtl/qea_host_loader.sv
// qea_host_loader: loads context/state into QEA, runs it, streams results back; QEA_HOST_CYCLE_CNT_EN adds o_exec_cycles.
module qea_host_loader
   import qea_host_pkg::*;
#(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = 32,
   parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = 64,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int READ_LAT                = DEF_READ_LAT
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_go,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_num,
   input  logic                                 i_ctx_valid,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
   output logic                                 o_ctx_ready,
   input  logic                                 i_st_valid,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_word,
   output logic                                 o_st_ready,
   output logic                                 o_rd_valid,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_word,
   output logic [STATE_ADDR_WIDTH-1:0]          o_rd_addr,
   input  logic                                 i_rd_ready,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_qea_ctx_en,
   output logic                                 o_qea_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
   output logic                                 o_qea_state_ena,
   output logic                                 o_qea_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
   input  logic                                 i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err
`ifdef QEA_HOST_CYCLE_CNT_EN
   ,output logic [31:0]                         o_exec_cycles
`endif
);
   localparam int SW = PE_NUM * STATE_DATA_WIDTH;
   localparam int AW = STATE_ADDR_WIDTH;
   localparam int CW = GATE_CONTEXT_ADDR_WIDTH;
   state_t                         r_state, w_next;
   logic [MAX_QBIT_WIDTH-1:0]      r_qbit;
   logic [CW-1:0]                  r_ctx_num, r_ctx_cnt;
   logic [AW-1:0]                  r_last, r_cnt;
   logic                           r_run1, r_iss, r_err;
   logic [READ_LAT-1:0]            r_pv;
   logic [AW-1:0]                  r_pa [READ_LAT];
   logic                           w_legal, w_accept, w_ctx_hs, w_st_hs, w_issue, w_pop, w_fvalid;
   logic [AW+SW-1:0]               w_fdata;
   logic [$clog2(READ_LAT+2)-1:0]  w_fcount;
   int                             w_infl;
   assign w_legal  = qbit_legal(int'(i_qbit_num), PE_NUM_WIDTH, AW);
   assign w_accept = r_state == S_IDLE && i_go && w_legal;
   always_comb begin
      w_infl = 0;
      for (int i = 0; i < READ_LAT; i++) w_infl += int'(r_pv[i]);
   end
   always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_accept) w_next = (i_ctx_num == '0) ? S_LOAD_STATE : S_LOAD_CTX;
         S_LOAD_CTX:   if (w_ctx_hs && r_ctx_cnt + CW'(1) == r_ctx_num) w_next = S_LOAD_STATE;
         S_LOAD_STATE: if (w_st_hs && r_cnt == r_last) w_next = S_START;
         S_START:      w_next = S_RUN;
         S_RUN:        if (!r_run1 && i_qea_complete) w_next = S_READ;
         S_READ:       if (w_pop && o_rd_addr == r_last) w_next = S_DONE;
         default:      w_next = S_IDLE;
      endcase
   end
   // reads are issued only while every outstanding word has a guaranteed skid slot
   always_comb begin
      o_ctx_ready       = r_state == S_LOAD_CTX;
      o_st_ready        = r_state == S_LOAD_STATE;
      w_ctx_hs          = o_ctx_ready && i_ctx_valid;
      w_st_hs           = o_st_ready && i_st_valid;
      w_issue           = r_state == S_READ && !r_iss && (int'(w_fcount) + w_infl < READ_LAT + 1);
      o_qea_ctx_en      = w_ctx_hs;
      o_qea_ctx_wea     = w_ctx_hs;
      o_qea_ctx_addr    = w_ctx_hs ? r_ctx_cnt : '0;
      o_qea_ctx_data    = w_ctx_hs ? i_ctx_word : '0;
      o_qea_state_ena   = w_st_hs || w_issue;
      o_qea_state_wea   = w_st_hs;
      o_qea_state_addra = (w_st_hs || w_issue) ? r_cnt : '0;
      o_qea_state_dina  = w_st_hs ? i_st_word : '0;
      o_qea_start       = r_state == S_START;
      o_busy            = r_state != S_IDLE;
      o_done            = r_state == S_DONE;
      o_rd_valid        = w_fvalid;
      o_rd_word         = w_fvalid ? w_fdata[SW-1:0] : '0;
      o_rd_addr         = w_fvalid ? w_fdata[AW+SW-1:SW] : '0;
      w_pop             = w_fvalid && i_rd_ready;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_qbit    <= '0;
         r_ctx_num <= '0;
         r_ctx_cnt <= '0;
         r_last    <= '0;
         r_cnt     <= '0;
         r_run1    <= 1'b0;
         r_iss     <= 1'b0;
         r_err     <= 1'b0;
         r_pv      <= '0;
      end else begin
         r_err <= r_state == S_IDLE && i_go && !w_legal;
         if (w_accept) begin
            r_qbit    <= i_qbit_num;
            r_ctx_num <= i_ctx_num;
            r_last    <= AW'(depth_of(int'(i_qbit_num), PE_NUM_WIDTH) - 1);
            r_ctx_cnt <= '0;
            r_cnt     <= '0;
            r_iss     <= 1'b0;
         end
         if (w_ctx_hs) r_ctx_cnt <= r_ctx_cnt + CW'(1);
         if (w_st_hs) r_cnt <= (r_cnt == r_last) ? '0 : r_cnt + AW'(1);
         if (w_issue) begin
            r_cnt <= r_cnt + AW'(1);
            r_iss <= r_cnt == r_last;
         end
         if (r_state == S_START) r_run1 <= 1'b1;
         if (r_state == S_RUN) r_run1 <= 1'b0;
         r_pv <= READ_LAT'({r_pv, w_issue});
      end
   end
   always_ff @(posedge clk) begin
      r_pa[0] <= r_cnt;
      for (int i = 1; i < READ_LAT; i++) r_pa[i] <= r_pa[i-1];
   end
   assign o_qea_qbit_num = r_qbit;
   assign o_err          = r_err;
   qea_host_rd_skid #(.DEPTH(READ_LAT + 1), .W(AW + SW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pv[READ_LAT-1]),
      .i_data  ({r_pa[READ_LAT-1], i_qea_state_dout}),
      .i_pop   (w_pop),
      .o_valid (w_fvalid),
      .o_data  (w_fdata),
      .o_count (w_fcount)
   );
`ifdef QEA_HOST_CYCLE_CNT_EN
   logic [31:0] r_exec;
   always_ff @(posedge clk) begin
      if (rst || r_state == S_START) r_exec <= '0;
      else if (r_state == S_RUN && r_exec != '1) r_exec <= r_exec + 32'd1;
   end
   assign o_exec_cycles = r_exec;
`endif
endmodule

// File: tb/tb_qea_host_loader.sv
// tb_qea_host_loader: directed jobs against a copy-through QEA model with a per-cycle scoreboard.
module tb_qea_host_loader;
   localparam int SW = 256;
   typedef struct {logic [15:0] a; logic [255:0] d;} wr_t;
   logic          clk = 0, rst = 1;
   logic          i_go = 0, i_ctx_valid = 0, i_st_valid = 0, i_rd_ready = 1;
   logic [5:0]    i_qbit_num = 0;
   logic [15:0]   i_ctx_num = 0;
   logic [63:0]   i_ctx_word = 0;
   logic [SW-1:0] i_st_word = 0;
   logic          o_ctx_ready, o_st_ready, o_rd_valid, o_qea_start, o_qea_ctx_en, o_qea_ctx_wea;
   logic          o_qea_state_ena, o_qea_state_wea, o_busy, o_done, o_err, i_qea_complete;
   logic [SW-1:0] o_rd_word, o_qea_state_dina, i_qea_state_dout;
   logic [15:0]   o_rd_addr, o_qea_ctx_addr, o_qea_state_addra;
   logic [5:0]    o_qea_qbit_num;
   logic [63:0]   o_qea_ctx_data;
   logic          any_out;
`ifdef QEA_HOST_CYCLE_CNT_EN
   logic [31:0]   o_exec_cycles;
`endif
   always #5 clk = ~clk;
   qea_host_loader #(.READ_LAT(2)) dut (
      .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ctx_num(i_ctx_num),
      .i_ctx_valid(i_ctx_valid), .i_ctx_word(i_ctx_word), .o_ctx_ready(o_ctx_ready),
      .i_st_valid(i_st_valid), .i_st_word(i_st_word), .o_st_ready(o_st_ready),
      .o_rd_valid(o_rd_valid), .o_rd_word(o_rd_word), .o_rd_addr(o_rd_addr), .i_rd_ready(i_rd_ready),
      .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num), .o_qea_ctx_en(o_qea_ctx_en),
      .o_qea_ctx_wea(o_qea_ctx_wea), .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
      .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
      .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
      .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef QEA_HOST_CYCLE_CNT_EN
      , .o_exec_cycles(o_exec_cycles)
`endif
   );
`ifdef QEA_HOST_CYCLE_CNT_EN
   assign any_out = |{o_ctx_ready, o_st_ready, o_rd_valid, o_rd_word, o_rd_addr, o_qea_start, o_qea_qbit_num,
                      o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena,
                      o_qea_state_wea, o_qea_state_addra, o_qea_state_dina, o_busy, o_done, o_err, o_exec_cycles};
`else
   assign any_out = |{o_ctx_ready, o_st_ready, o_rd_valid, o_rd_word, o_rd_addr, o_qea_start, o_qea_qbit_num,
                      o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena,
                      o_qea_state_wea, o_qea_state_addra, o_qea_state_dina, o_busy, o_done, o_err};
`endif
   // QEA stand-in: state RAM with two-cycle read latency, complete raised 10 cycles after start
   logic [SW-1:0] st_mem [64];
   logic [SW-1:0] rd1 = 0, rd2 = 0;
   int            since = 0;
   always @(posedge clk) begin
      if (o_qea_state_ena && o_qea_state_wea) st_mem[o_qea_state_addra[5:0]] <= o_qea_state_dina;
      if (o_qea_state_ena && !o_qea_state_wea) rd1 <= st_mem[o_qea_state_addra[5:0]];
      rd2 <= rd1;
      since <= rst ? 0 : o_qea_start ? 1 : (since != 0 && since < 1000) ? since + 1 : since;
   end
   assign i_qea_state_dout = rd2;
   assign i_qea_complete   = since >= 10;
   int errors = 0, checks = 0;
   int n_ctxw = 0, n_stw = 0, n_start = 0;
   wr_t q_ctx[$], q_st[$], q_rd[$];
   logic [15:0]  log_addr[$];
   logic [255:0] log_word[$];
   bit           m_rst_prev = 1, m_active = 0, m_done_nx = 0, m_err_nx = 0, m_start_nx = 0, m_stall = 0;
   logic [5:0]   m_qbit = 0;
   logic [15:0]  m_addr = 0;
   logic [255:0] m_word = 0;
   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic bit legal(input int q);
      return q > 2 && q <= 18;
   endfunction
   function automatic logic [63:0] ctxw(input int jid, input int k);
      return {16'hC0DE, 16'(jid), 32'(k)};
   endfunction
   function automatic logic [255:0] stw(input int jid, input int k);
      logic [255:0] w;
      if (jid == 0) return (k == 0) ? 256'h4000000000000000 : 256'h0;
      for (int p = 0; p < 4; p++) w[p*64 +: 64] = {24'hA5A5A5, 8'(jid), 16'(k), 16'(p)};
      return w;
   endfunction
   always @(negedge clk) begin
      wr_t e;
      bit nx_done, nx_start;
      nx_done = 0;
      nx_start = 0;
      if (m_rst_prev) chk("reset_outputs_zero", any_out, 0);
      else begin
         chk("busy", o_busy, m_active);
         chk("done", o_done, m_done_nx);
         chk("err", o_err, m_err_nx);
         chk("start", o_qea_start, m_start_nx);
         if (m_active) chk("qbit_num", o_qea_qbit_num, m_qbit);
         if (o_qea_start) n_start++;
         if (o_qea_ctx_en || o_qea_ctx_wea) begin
            n_ctxw++;
            if (q_ctx.size() == 0) chk("ctx_unexpected", {o_qea_ctx_en, o_qea_ctx_wea}, 0);
            else begin
               e = q_ctx.pop_front();
               chk("ctx_write", {o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data}, {2'b11, e.a, e.d[63:0]});
            end
         end
         if (o_qea_state_ena && o_qea_state_wea) begin
            n_stw++;
            if (q_st.size() == 0) chk("state_unexpected", o_qea_state_wea, 0);
            else begin
               e = q_st.pop_front();
               chk("state_write", {o_qea_state_addra, o_qea_state_dina}, {e.a, e.d});
               nx_start = q_st.size() == 0;
            end
         end
         if (o_qea_state_ena && !o_qea_state_wea && !m_active) chk("read_when_idle", o_qea_state_ena, 0);
         if (m_stall) chk("stall_hold", {o_rd_valid, o_rd_addr, o_rd_word}, {1'b1, m_addr, m_word});
         if (o_rd_valid && i_rd_ready) begin
            log_addr.push_back(o_rd_addr);
            log_word.push_back(o_rd_word);
            if (q_rd.size() == 0) chk("rd_unexpected", o_rd_valid, 0);
            else begin
               e = q_rd.pop_front();
               chk("rd_word", {o_rd_addr, o_rd_word}, {e.a, e.d});
               nx_done = q_rd.size() == 0;
            end
         end
      end
      m_done_nx  = !rst && nx_done;
      m_start_nx = !rst && nx_start;
      m_err_nx   = !rst && !m_active && i_go && !legal(int'(i_qbit_num));
      m_stall    = !rst && o_rd_valid && !i_rd_ready;
      m_addr     = o_rd_addr;
      m_word     = o_rd_word;
      if (rst) begin
         m_active = 0;
         q_ctx.delete();
         q_st.delete();
         q_rd.delete();
      end else if (!m_active && i_go && legal(int'(i_qbit_num))) begin
         m_active = 1;
         m_qbit   = i_qbit_num;
      end else if (o_done) m_active = 0;
      m_rst_prev = rst;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic job(input int jid, input int qbit, input int nctx, input logic [3:0] pat, input bit abort);
      int  depth, n, idx;
      wr_t e;
      depth = 1 << (qbit - 2);
      n_ctxw = 0;
      n_stw = 0;
      n_start = 0;
      log_addr.delete();
      log_word.delete();
      for (int k = 0; k < nctx; k++) begin
         e.a = 16'(k);
         e.d = 256'(ctxw(jid, k));
         q_ctx.push_back(e);
      end
      for (int k = 0; k < depth; k++) begin
         e.a = 16'(k);
         e.d = stw(jid, k);
         q_st.push_back(e);
         q_rd.push_back(e);
      end
      i_go = 1;
      i_qbit_num = 6'(qbit);
      i_ctx_num = 16'(nctx);
      tick();
      i_go = 0;
      @(negedge clk);
      chk("first_phase_ready", {o_ctx_ready, o_st_ready}, (nctx == 0) ? 2'b01 : 2'b10);
      tick();
      for (int k = 0; k < nctx; k++) begin
         i_ctx_valid = 1;
         i_ctx_word = ctxw(jid, k);
         n = 0;
         while (!o_ctx_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) chk("ctx_ready_timeout", o_ctx_ready, 1);
         tick();
      end
      i_ctx_valid = 0;
      for (int k = 0; k < depth; k++) begin
         i_st_valid = 1;
         i_st_word = stw(jid, k);
         n = 0;
         while (!o_st_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) chk("st_ready_timeout", o_st_ready, 1);
         tick();
      end
      i_st_valid = 0;
      if (abort) begin
         n = 0;
         while (!o_qea_start && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) chk("start_timeout", o_qea_start, 1);
         repeat (3) tick();
         rst = 1;
         tick();
         rst = 0;
         repeat (3) tick();
         return;
      end
      idx = 0;
      n = 0;
      while (n < 500) begin
         i_rd_ready = pat[3 - (idx % 4)];
         idx++;
         @(negedge clk);
         if (o_done) break;
         tick();
         n++;
      end
      if (n >= 500) chk("done_timeout", o_done, 1);
      i_rd_ready = 1;
`ifdef QEA_HOST_CYCLE_CNT_EN
      chk("exec_cycles", o_exec_cycles, 10);
`endif
      tick();
   endtask
   task automatic bad_go(input int q);
      i_go = 1;
      i_qbit_num = 6'(q);
      tick();
      i_go = 0;
      @(negedge clk);
      chk("err_pulse", o_err, 1);
      chk("err_busy", o_busy, 0);
      tick();
      @(negedge clk);
      chk("err_one_cycle", o_err, 0);
      tick();
   endtask
   initial begin
      repeat (3) tick();
      rst = 0;
      tick();
      job(0, 4, 3, 4'b1111, 0);
      chk("basic_ctx_writes", n_ctxw, 3);
      chk("basic_state_writes", n_stw, 4);
      chk("basic_starts", n_start, 1);
      chk("basic_rd_count", log_word.size(), 4);
      chk("basic_word0", log_word[0], 256'h4000000000000000);
      chk("basic_addr3", log_addr[3], 3);
      bad_go(2);
      bad_go(19);
      job(1, 4, 0, 4'b1111, 0);
      chk("ctx0_no_ctx_writes", n_ctxw, 0);
      chk("ctx0_state_writes", n_stw, 4);
      job(2, 4, 2, 4'b1001, 0);
      chk("bp_rd_count", log_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk("bp_addr_order", log_addr[i], i);
      job(3, 5, 1, 4'b1111, 1);
      chk("abort_idle", o_busy, 0);
      job(4, 5, 2, 4'b1010, 0);
      chk("after_abort_rd_count", log_addr.size(), 8);
      job(5, 3, 1, 4'b1111, 0);
      chk("min_qbit_rd_count", log_addr.size(), 2);
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
